// File: rtl/kpd_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, key-to-matrix map, bounce LFSR.
package kpd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE
  } state_t;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_pos_t;

  // Entry n is the matrix position of hex key n, packed {col,row}; entry 15 is the leftmost digit.
  localparam key_pos_t [15:0] KEY_MAP = 64'h8401_2359_D6AE_7BFC;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [2:0] BOUNCE_CYC = 3'd6;

endpackage

// File: rtl/kpd_emulator_if.sv
// Key request handshake and status between the demo sequencer (master) and the emulator (slave).
interface kpd_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output key_valid, key_code, input key_ready, busy, done, err);
  modport slave  (input key_valid, key_code, output key_ready, busy, done, err);
endinterface

// File: rtl/kpd_col_edge.sv
// Registers the scanner's column drive and flags new activations (1->0) and any change.
module kpd_col_edge (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] act,
  output logic       changed
);

  logic [3:0] col_q;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) col_q <= 4'hF;
    else     col_q <= col_n;
  end

  assign act     = col_q & ~col_n;
  assign changed = |(col_q ^ col_n);

endmodule

// File: rtl/kpd_emulator.sv
// Keypad far-end emulator: presses one hex key per handshake against the scanner's column drive.
// Optional contact-bounce model on entry to PRESS: define KPD_EMU_BOUNCE_EN.
//
//   state   | meaning
//   IDLE    | key_ready high, rows released
//   PRESS   | row follows the key's column until the hold count is reached
//   RELEASE | rows released, counting column-0 scans before the next key
module kpd_emulator
  import kpd_pkg::*;
#(
  parameter int HOLD_SCANS    = 4,
  parameter int RELEASE_SCANS = 2,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic            slow_clk,
  input  logic            rst,
  kpd_emulator_if.slave   kif,
  input  logic [3:0]      col_n,
  output logic [3:0]      row_n
);

  localparam int HOLD_MAX = (HOLD_SCANS < 1) ? 1 : HOLD_SCANS;
  localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]       HOLD_TC = 8'(HOLD_MAX);
  localparam logic [7:0]       REL_TC  = 8'(RELEASE_SCANS);
  localparam logic [TMO_W-1:0] TMO_TC  = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [7:0]       hold_cnt;
  logic [7:0]       rel_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_q;
  logic             err_q;
  logic [3:0]       act;
  logic             changed;
  logic             tmo_hit;
  logic             scan_en;
  logic             drive_gate;

  kpd_col_edge u_col_edge (
    .slow_clk (slow_clk),
    .rst      (rst),
    .col_n    (col_n),
    .act      (act),
    .changed  (changed)
  );

`ifdef KPD_EMU_BOUNCE_EN
  logic [7:0] lfsr;
  logic [2:0] bnc_cnt;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst)                  bnc_cnt <= '0;
    else if (state != PRESS)  bnc_cnt <= '0;
    else if (!scan_en)        bnc_cnt <= bnc_cnt + 3'd1;
  end

  assign scan_en    = (bnc_cnt == BOUNCE_CYC);
  assign drive_gate = scan_en | lfsr[0];
`else
  assign scan_en    = 1'b1;
  assign drive_gate = 1'b1;
`endif

  // Any column movement proves the scanner is alive, so only a frozen bus times out.
  assign tmo_hit = (state != IDLE) && !changed && (tmo_cnt == TMO_TC);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst)                           tmo_cnt <= '0;
    else if (state == IDLE || changed) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col_idx  <= '0;
      row_idx  <= '0;
      hold_cnt <= '0;
      rel_cnt  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (kif.key_valid) begin
            col_idx  <= KEY_MAP[kif.key_code].col;
            row_idx  <= KEY_MAP[kif.key_code].row;
            hold_cnt <= '0;
            rel_cnt  <= '0;
            state    <= PRESS;
          end
        end
        PRESS: begin
          if (tmo_hit) begin
            state <= IDLE;
            err_q <= 1'b1;
          end else if (scan_en && act[col_idx]) begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt + 8'd1 == HOLD_TC) state <= RELEASE;
          end
        end
        RELEASE: begin
          if (tmo_hit) begin
            state <= IDLE;
            err_q <= 1'b1;
          end else if (REL_TC == 8'd0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (act[0]) begin
            rel_cnt <= rel_cnt + 8'd1;
            if (rel_cnt + 8'd1 == REL_TC) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational so the scanner's mid-cycle sample sees the row in the same cycle as its column.
  always_comb begin
    row_n = 4'hF;
    if (state == PRESS) row_n[row_idx] = col_n[col_idx] | ~drive_gate;
  end

  assign kif.key_ready = (state == IDLE);
  assign kif.busy      = (state != IDLE);
  assign kif.done      = done_q;
  assign kif.err       = err_q;

endmodule

// File: tb/tb_kpd_emulator.sv
// Bench for kpd_emulator: rotating column scanner, keypad-layout decoder and per-cycle row model.
module tb_kpd_emulator;

  localparam int HOLD     = 4;
  localparam int REL      = 2;
  localparam int TMO      = 64;
  localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;

  logic       slow_clk = 1'b0;
  logic       rst      = 1'b0;
  logic [3:0] col_n    = 4'hF;
  logic [3:0] row_n;

  kpd_emulator_if kif ();

  kpd_emulator #(
    .HOLD_SCANS    (HOLD),
    .RELEASE_SCANS (REL),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .kif      (kif),
    .col_n    (col_n),
    .row_n    (row_n)
  );

  always #5 slow_clk = ~slow_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int phase = 0;
  bit rotate = 1'b0;

  // Physical keypad: pad[row][col], col 0 = J1 ... col 3 = J4.
  int pad [4][4] = '{'{4'hD, 4'hE, 4'hF, 4'h0},
                     '{4'hC, 4'h9, 4'h8, 4'h7},
                     '{4'hB, 4'h6, 4'h5, 4'h4},
                     '{4'hA, 4'h3, 4'h2, 4'h1}};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
    if (rotate) begin
      phase = (phase + 1) % 4;
      col_n = ~(4'b0001 << phase);
    end
    @(negedge slow_clk);
  endtask

  task automatic find_pos(input int code, output int c, output int r);
    c = 0;
    r = 0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (pad[rr][cc] == code) begin
          c = cc;
          r = rr;
        end
  endtask

  task automatic wait_accept(input int code, output bit acc);
    int w;
    kif.key_valid = 1'b1;
    kif.key_code  = 4'(code);
    acc = 1'b0;
    w   = 0;
    while (!acc && w < 20) begin
      acc = kif.key_ready;
      tick();
      w++;
    end
    check_eq($sformatf("accept_%h", code), int'(acc), 1);
  endtask

  task automatic press(input int code, input bit hold_next, input int next_code);
    int c, r, n, rr, hold_seen, rel_seen, exp_done, done_at;
    int nsamp, code_err, row_err, ready_err, illegal, saw_err;
    bit acc;
    logic [3:0] exp_row;
    find_pos(code, c, r);
    wait_accept(code, acc);
    if (!acc) begin
      kif.key_valid = 1'b0;
      return;
    end
    if (hold_next) kif.key_code = 4'(next_code);
    else           kif.key_valid = 1'b0;
    n = 0; hold_seen = 0; rel_seen = 0; exp_done = -2; done_at = -1;
    nsamp = 0; code_err = 0; row_err = 0; ready_err = 0; illegal = 0; saw_err = 0;
    while (n < 300) begin
      exp_row = 4'hF;
      if (hold_seen < HOLD_EFF && col_n[c] == 1'b0) begin
        exp_row[r] = 1'b0;
        hold_seen++;
        if (hold_seen == HOLD_EFF && REL == 0) exp_done = n + 2;
      end else if (hold_seen == HOLD_EFF && col_n[0] == 1'b0 && rel_seen < REL) begin
        rel_seen++;
        if (rel_seen == REL) exp_done = n + 1;
      end
      if (row_n !== exp_row) row_err++;
      if (row_n !== 4'hF) begin
        if ($countones(~row_n) == 1 && $countones(~col_n) == 1) begin
          rr = 0;
          for (int b = 0; b < 4; b++) if (row_n[b] == 1'b0) rr = b;
          nsamp++;
          if (pad[rr][phase] != code) code_err++;
        end else begin
          illegal++;
        end
      end
      if (kif.err) saw_err = 1;
      if (kif.done || kif.err) break;
      if (kif.key_ready) ready_err++;
      tick();
      n++;
    end
    if (kif.done) done_at = n;
    check_eq($sformatf("samples_%h", code), nsamp, HOLD_EFF);
    check_eq($sformatf("decode_%h", code), code_err, 0);
    check_eq($sformatf("row_model_%h", code), row_err, 0);
    check_eq($sformatf("illegal_row_%h", code), illegal, 0);
    check_eq($sformatf("done_cycle_%h", code), done_at, exp_done);
    check_eq($sformatf("no_err_%h", code), saw_err, 0);
    check_eq($sformatf("ready_while_busy_%h", code), ready_err, 0);
    check_eq($sformatf("idle_after_done_%h", code), int'({kif.key_ready, kif.busy}), 2);
    if (!hold_next) begin
      tick();
      check_eq($sformatf("done_pulse_%h", code), int'(kif.done), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cur, nxt, n, rows_low, done_seen, w;
    bit h, acc;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;

    #1 rst = 1'b1;
    #2;
    check_eq("rst_row_n", int'(row_n), 15);
    check_eq("rst_key_ready", int'(kif.key_ready), 1);
    check_eq("rst_busy", int'(kif.busy), 0);
    check_eq("rst_done", int'(kif.done), 0);
    check_eq("rst_err", int'(kif.err), 0);
    tick();
    tick();
    rst    = 1'b0;
    rotate = 1'b1;
    repeat (3) tick();

    press(5, 1'b0, 0);

    for (int k = 0; k < 16; k++) begin
      press(k, 1'b0, 0);
      repeat ($urandom_range(0, 5)) tick();
    end

    press(5, 1'b1, 9);
    press(9, 1'b0, 0);

    nxt = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) begin
      cur = nxt;
      nxt = $urandom_range(0, 15);
      h   = (i < 15) && ($urandom_range(0, 1) == 1);
      press(cur, h, nxt);
      if (!h) repeat ($urandom_range(0, 5)) tick();
    end

    // Frozen column bus: the press must abort after TMO quiet cycles.
    rotate = 1'b0;
    col_n  = 4'hF;
    repeat (3) tick();
    wait_accept(4'hA, acc);
    kif.key_valid = 1'b0;
    n = 0; rows_low = 0; done_seen = 0;
    while (!kif.err && n < 200) begin
      if (row_n !== 4'hF) rows_low++;
      if (kif.done) done_seen++;
      tick();
      n++;
    end
    check_eq("tmo_cycles", n, TMO);
    check_eq("tmo_row_n", int'(row_n), 15);
    check_eq("tmo_rows_low", rows_low, 0);
    check_eq("tmo_no_done", done_seen + int'(kif.done), 0);
    check_eq("tmo_idle", int'({kif.key_ready, kif.busy}), 2);
    tick();
    check_eq("tmo_err_pulse", int'(kif.err), 0);
    rotate = 1'b1;
    repeat (4) tick();

    // Reset in the middle of a press must release the row without waiting for a clock.
    wait_accept(4'hD, acc);
    kif.key_valid = 1'b0;
    w = 0;
    while (row_n === 4'hF && w < 20) begin
      tick();
      w++;
    end
    check_eq("rst_mid_row_seen", int'(row_n !== 4'hF), 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_row_n", int'(row_n), 15);
    check_eq("rst_mid_idle", int'({kif.key_ready, kif.busy}), 2);
    tick();
    tick();
    rst = 1'b0;
    press(4'hD, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
